// File: rtl/uart_calc_ctrl.sv
// Sequencer for the UART calculator: collects A, B and opcode words, waits
// out the ALU settle time, then ships the result. Define SEND_HI_EN to also send result_hi.
module uart_calc_ctrl #(
    parameter int unsigned ALU_LATENCY    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_word_in,
    input  logic        i_word_done,
    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    output logic [3:0]  o_alu_op,
    input  logic [31:0] i_alu_lo,
    input  logic [31:0] i_alu_hi,
    output logic [31:0] o_tx_word,
    output logic        o_tx_send,
    input  logic        i_tx_done,
    output logic        o_busy,
    output logic        o_frame_err,
    output logic        o_overrun
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned LAT_W  = 4;
    localparam int unsigned TMO_W  = 32;
    localparam logic              TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LAT_W-1:0]  LAT_INIT = LAT_W'(ALU_LATENCY - 1);

    typedef enum logic [2:0] {
        S_WAIT_A,
        S_WAIT_B,
        S_WAIT_OP,
        S_EXEC,
        S_SEND_LO,
        S_WAIT_LO
`ifdef SEND_HI_EN
        , S_SEND_HI
        , S_WAIT_HI
`endif
    } state_t;

    state_t              r_state, w_state;
    logic [WORD_W-1:0]   r_alu_a, w_alu_a;
    logic [WORD_W-1:0]   r_alu_b, w_alu_b;
    logic [OP_W-1:0]     r_alu_op, w_alu_op;
    logic [WORD_W-1:0]   r_tx_word, w_tx_word;
    logic                r_tx_send, w_tx_send;
    logic                r_busy, w_busy;
    logic                r_frame_err, w_frame_err;
    logic                r_overrun, w_overrun;
    logic [TMO_W-1:0]    r_tcnt, w_tcnt;
    logic [LAT_W-1:0]    r_lcnt, w_lcnt;
    logic                w_tmo;
`ifdef SEND_HI_EN
    logic [WORD_W-1:0]   r_hi, w_hi;
`else
    logic                w_unused_hi;
    assign w_unused_hi = ^i_alu_hi;
`endif

    assign w_tmo = TMO_EN && (r_tcnt == TMO_LAST);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_WAIT_A;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_tx_word   <= '0;
            r_tx_send   <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_tcnt      <= '0;
            r_lcnt      <= '0;
`ifdef SEND_HI_EN
            r_hi        <= '0;
`endif
        end else begin
            r_state     <= w_state;
            r_alu_a     <= w_alu_a;
            r_alu_b     <= w_alu_b;
            r_alu_op    <= w_alu_op;
            r_tx_word   <= w_tx_word;
            r_tx_send   <= w_tx_send;
            r_busy      <= w_busy;
            r_frame_err <= w_frame_err;
            r_overrun   <= w_overrun;
            r_tcnt      <= w_tcnt;
            r_lcnt      <= w_lcnt;
`ifdef SEND_HI_EN
            r_hi        <= w_hi;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state     = r_state;
        w_alu_a     = r_alu_a;
        w_alu_b     = r_alu_b;
        w_alu_op    = r_alu_op;
        w_tx_word   = r_tx_word;
        w_tx_send   = 1'b0;
        w_frame_err = 1'b0;
        w_overrun   = r_overrun;
        w_tcnt      = r_tcnt;
        w_lcnt      = r_lcnt;
`ifdef SEND_HI_EN
        w_hi        = r_hi;
`endif
        case (r_state)
            S_WAIT_A: begin
                if (i_word_done) begin
                    w_alu_a = i_word_in;
                    w_tcnt  = '0;
                    w_state = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (i_word_done) begin
                    w_alu_b = i_word_in;
                    w_tcnt  = '0;
                    w_state = S_WAIT_OP;
                end else if (w_tmo) begin
                    w_frame_err = 1'b1;
                    w_tcnt      = '0;
                    w_state     = S_WAIT_A;
                end else begin
                    w_tcnt = r_tcnt + TMO_W'(1);
                end
            end
            S_WAIT_OP: begin
                if (i_word_done) begin
                    w_alu_op = i_word_in[OP_W-1:0];
                    w_lcnt   = LAT_INIT;
                    w_tcnt   = '0;
                    w_state  = S_EXEC;
                end else if (w_tmo) begin
                    w_frame_err = 1'b1;
                    w_tcnt      = '0;
                    w_state     = S_WAIT_A;
                end else begin
                    w_tcnt = r_tcnt + TMO_W'(1);
                end
            end
            S_EXEC: begin
                if (r_lcnt == '0) begin
                    w_tx_word = i_alu_lo;
                    w_tx_send = 1'b1;
`ifdef SEND_HI_EN
                    w_hi      = i_alu_hi;
`endif
                    w_state   = S_SEND_LO;
                end else begin
                    w_lcnt = r_lcnt - LAT_W'(1);
                end
            end
            S_SEND_LO: w_state = S_WAIT_LO;
            S_WAIT_LO: begin
                if (i_tx_done) begin
`ifdef SEND_HI_EN
                    w_tx_word = r_hi;
                    w_tx_send = 1'b1;
                    w_state   = S_SEND_HI;
`else
                    w_state   = S_WAIT_A;
`endif
                end
            end
`ifdef SEND_HI_EN
            S_SEND_HI: w_state = S_WAIT_HI;
            S_WAIT_HI: begin
                if (i_tx_done) w_state = S_WAIT_A;
            end
`endif
            default: w_state = S_WAIT_A;
        endcase
        // r_busy mirrors the current state, so a word seen now is dropped
        if (i_word_done && r_busy) w_overrun = 1'b1;
        w_busy = (w_state != S_WAIT_A) && (w_state != S_WAIT_B) && (w_state != S_WAIT_OP);
    end

    assign o_alu_a     = r_alu_a;
    assign o_alu_b     = r_alu_b;
    assign o_alu_op    = r_alu_op;
    assign o_tx_word   = r_tx_word;
    assign o_tx_send   = r_tx_send;
    assign o_busy      = r_busy;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
endmodule

// File: tb/tb_uart_calc_ctrl.sv
// Directed plus randomized frames against uart_calc_ctrl, with an ALU stub
// and a bench-side transmitter handshake.
module tb_uart_calc_ctrl;
    localparam int unsigned LAT = 2;
    localparam int unsigned TMO = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] word_in = '0;
    logic        word_done = 1'b0;
    logic [31:0] alu_a, alu_b, alu_lo, alu_hi, tx_word;
    logic [3:0]  alu_op;
    logic        tx_send, busy, frame_err, overrun;
    logic        tx_done = 1'b0;
    logic        hi_corrupt = 1'b0;
    logic        ovr_exp = 1'b0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] f_lo(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a ^ b;
            4'd2:    return a - b;
            default: return (a & b) ^ {28'h0, op};
        endcase
    endfunction

    function automatic logic [31:0] f_hi(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        if (op == 4'd0) return b;
        return a ^ {b[15:0], b[31:16]};
    endfunction

    assign alu_lo = f_lo(alu_a, alu_b, alu_op);
    assign alu_hi = hi_corrupt ? 32'hBAD0_BAD0 : f_hi(alu_a, alu_b, alu_op);

    uart_calc_ctrl #(.ALU_LATENCY(LAT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_word_in(word_in), .i_word_done(word_done),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
        .i_alu_lo(alu_lo), .i_alu_hi(alu_hi),
        .o_tx_word(tx_word), .o_tx_send(tx_send), .i_tx_done(tx_done),
        .o_busy(busy), .o_frame_err(frame_err), .o_overrun(overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        word_in   = w;
        word_done = 1'b1;
        tick();
        word_done = 1'b0;
        word_in   = $urandom;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a"}, alu_a, 0);
        chk({tag, "_b"}, alu_b, 0);
        chk({tag, "_op"}, 32'(alu_op), 0);
        chk({tag, "_txw"}, tx_word, 0);
        chk({tag, "_send"}, 32'(tx_send), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ferr"}, 32'(frame_err), 0);
        chk({tag, "_ovr"}, 32'(overrun), 0);
    endtask

    // mode: 0 plain, 1 stray word in WAIT_LO, 2 stray word with tx_done, 3 tx_done alongside tx_send
    task automatic run_frame(input logic [31:0] a, input logic [31:0] b, input logic [31:0] opw, input int mode);
        logic [31:0] lo, hi;
        int n;
        lo = f_lo(a, b, opw[3:0]);
        hi = f_hi(a, b, opw[3:0]);
        send_word(a);
        chk("a_busy", 32'(busy), 0);
        chk("alu_a", alu_a, a);
        repeat ($urandom_range(0, 3)) tick();
        send_word(b);
        chk("alu_b", alu_b, b);
        repeat ($urandom_range(0, 3)) tick();
        send_word(opw);
        chk("alu_op", 32'(alu_op), 32'(opw[3:0]));
        chk("exec_busy", 32'(busy), 1);
        n = 0;
        while (tx_send !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'(LAT));
        chk("tx_lo", tx_word, lo);
        chk("hold_a", alu_a, a);
        chk("hold_b", alu_b, b);
        hi_corrupt = 1'b1;
        if (mode == 3) begin
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end else begin
            tick();
        end
        chk("send_pulse", 32'(tx_send), 0);
        repeat ($urandom_range(0, 4)) tick();
        chk("wait_busy", 32'(busy), 1);
        if (mode == 1) begin
            send_word(32'hDEAD_BEEF);
            ovr_exp = 1'b1;
            chk("ovr_set", 32'(overrun), 1);
            chk("ovr_keep_a", alu_a, a);
            chk("ovr_busy", 32'(busy), 1);
        end
        tx_done = 1'b1;
        if (mode == 2) begin
            word_in   = 32'h0BAD_F00D;
            word_done = 1'b1;
            ovr_exp   = 1'b1;
        end
        tick();
        tx_done   = 1'b0;
        word_done = 1'b0;
`ifdef SEND_HI_EN
        chk("tx_hi_send", 32'(tx_send), 1);
        chk("tx_hi", tx_word, hi);
        hi_corrupt = 1'b0;
        tick();
        chk("hi_pulse", 32'(tx_send), 0);
        chk("hi_busy", 32'(busy), 1);
        repeat ($urandom_range(0, 3)) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
`else
        hi_corrupt = 1'b0;
        if (hi != 32'h0) hi = 32'h0;
`endif
        chk("done_busy", 32'(busy), 0);
        chk("done_send", 32'(tx_send), 0);
        chk("overrun", 32'(overrun), 32'(ovr_exp));
    endtask

    initial begin
        int n;
        int extra;
        logic seen;
        logic [31:0] ta, tb;

        tick();
        tick();
        chk_all_zero("rst");
        rst = 1'b0;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("idle_done_busy", 32'(busy), 0);
        chk("idle_done_send", 32'(tx_send), 0);

        run_frame(32'h5, 32'h3, 32'h0, 0);
        run_frame(32'hFFFF_FFFF, 32'h1, 32'h0, 0);
        run_frame(32'hFFFF_6667, 32'h0000_ABCD, 32'h0, 0);
        for (int i = 0; i < 8; i++)
            run_frame($urandom, $urandom, $urandom, (i % 2 == 1) ? 3 : 0);

        // Timeout from WAIT_B
        send_word(32'h11);
        n = 0;
        while (frame_err !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("tmo_b_cycles", 32'(n), 32'(TMO));
        chk("tmo_idle", 32'(busy), 0);
        extra = 0;
        repeat (10) begin
            tick();
            if (frame_err === 1'b1) extra++;
        end
        chk("tmo_single", 32'(extra), 0);
        chk("tmo_stale_a", alu_a, 32'h11);

        // Word in WAIT_B restarts the count; then time out in WAIT_OP
        ta = $urandom;
        tb = $urandom;
        send_word(ta);
        repeat (30) tick();
        send_word(tb);
        n = 0;
        while (frame_err !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("tmo_op_cycles", 32'(n), 32'(TMO));
        chk("tmo_stale_b", alu_b, tb);
        run_frame($urandom, $urandom, 32'h2, 0);

        run_frame($urandom, $urandom, $urandom, 1);
        run_frame($urandom, $urandom, $urandom, 0);

        // Asynchronous reset while in EXEC
        send_word($urandom);
        send_word($urandom);
        send_word(32'h1);
        tick();
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        #3;
        rst = 1'b0;
        ovr_exp = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (tx_send === 1'b1) seen = 1'b1;
        end
        chk("rst_no_send", 32'(seen), 0);

        run_frame($urandom, $urandom, $urandom, 2);
        run_frame($urandom, $urandom, $urandom, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_calc_ctrl.md
Name: uart_calc_ctrl

Overview:
- Sequencer for the UART calculator datapath.
- Collects three 32-bit words from the word receiver: operand A, operand B, then opcode (bits [3:0]).
- Holds the operands and opcode stable on the ALU inputs, waits a fixed settle time, then hands result_lo (optionally result_hi) to the word transmitter over a send/done handshake.
- Replaces ad-hoc edge-triggered capture logic with a single-clock FSM that has a frame timeout and error reporting.

Parameters:
- ALU_LATENCY, 2: cycles the ALU inputs are held stable before the result is sampled. Legal range 1..15.
- TIMEOUT_CYCLES, 1000000: idle cycles allowed between words of one frame. A value of 0 disables the timeout.

Ports:
- clk  input  1  system clock (divided 1 MHz domain).
- rst  input  1  asynchronous, active-high reset.
- word_in  input  32  word from the word receiver; valid when word_done=1.
- word_done  input  1  one-cycle strobe; word_in is valid.
- alu_a  output  32  operand A to the ALU.
- alu_b  output  32  operand B to the ALU.
- alu_op  output  4  op select to the ALU.
- alu_lo  input  32  ALU result_lo.
- alu_hi  input  32  ALU result_hi.
- tx_word  output  32  word to the word transmitter.
- tx_send  output  1  one-cycle strobe; start sending tx_word.
- tx_done  input  1  one-cycle strobe; the word transmitter has finished the whole word.
- busy  output  1  high in EXEC / SEND / WAIT states.
- frame_err  output  1  one-cycle pulse on frame timeout.
- overrun  output  1  sticky; a word arrived while busy. Cleared only by rst.

Behaviour:
- Reset (async, rst=1): state=WAIT_A; all of the following are 0: alu_a, alu_b, alu_op, tx_word, tx_send, frame_err, overrun, timeout counter, latency counter.
- All outputs are registered. tx_send and frame_err are single-cycle pulses.
- States: WAIT_A -> WAIT_B -> WAIT_OP -> EXEC -> SEND_LO -> WAIT_LO -> WAIT_A.
  - With SEND_HI_EN defined, WAIT_LO instead goes -> SEND_HI -> WAIT_HI -> WAIT_A.
- WAIT_A: on word_done, alu_a<=word_in; go to WAIT_B.
- WAIT_B: on word_done, alu_b<=word_in; go to WAIT_OP.
- WAIT_OP: on word_done, alu_op<=word_in[3:0] (bits [31:4] ignored); latency counter<=ALU_LATENCY-1; go to EXEC.
- EXEC: hold ALU inputs, decrement the counter each cycle.
  - When the counter is 0: tx_word<=alu_lo, tx_send<=1, go to SEND_LO.
  - Latency: opcode word_done sampled in cycle N -> tx_send high in cycle N+1+ALU_LATENCY.
- SEND_LO: tx_send returns to 0; go to WAIT_LO. This state lasts exactly one cycle.
- WAIT_LO: wait for tx_done.
  - tx_done is ignored in every other state.
  - tx_done in the same cycle as tx_send is ignored.
- Timeout: the counter runs only in WAIT_B and WAIT_OP.
  - It clears on word_done and on state entry.
  - When it reaches TIMEOUT_CYCLES-1: frame_err pulses, state returns to WAIT_A, and alu_a/alu_b/alu_op keep their stale values.
- Overrun: word_done in EXEC, SEND_*, or WAIT_* sets overrun. The word is dropped and the state is unaffected.
- busy=1 in EXEC, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI; 0 otherwise.
- A word_done arriving in the cycle that WAIT_LO/WAIT_HI returns to WAIT_A counts as overrun (the state was busy when it was sampled).
- Reset mid-frame or mid-send: immediate return to the reset values. The transmitter is not notified; the bench must reset it too.
- No arithmetic is done inside this block; all widths pass through unchanged.

Optional Feature:
- Macro: SEND_HI_EN.
- Defined:
  - After tx_done in WAIT_LO: tx_word<=alu_hi, tx_send pulses, go to SEND_HI, then WAIT_HI.
  - tx_done in WAIT_HI -> WAIT_A.
  - alu_hi is sampled at the same EXEC exit as alu_lo, into a holding register, so a later change on alu_hi has no effect.
- Undefined: only result_lo is sent; the alu_hi port is present but unused. SEND_HI, WAIT_HI, and the holding register are not built.

Test Plan:
1. Normal frame: word_done with 0x00000005, 0x00000003, 0x00000000; ALU stub sets alu_lo=a+b.
   - alu_a=5, alu_b=3, alu_op=0.
   - tx_send pulses 3 cycles after the third strobe with tx_word=0x00000008.
   - busy stays 1 until tx_done, then returns to 0.
2. Back-to-back frames: second frame 0xFFFFFFFF, 0x00000001, 0x00000000 after tx_done.
   - tx_word=0x00000000.
   - overrun stays 0.
3. Timeout: TIMEOUT_CYCLES=50; send A=0x11 only and wait 60 cycles.
   - frame_err pulses exactly once, 50 cycles after the A strobe; state is back in WAIT_A.
   - The next three words form a fresh frame.
4. Overrun: pulse word_done with 0xDEADBEEF during WAIT_LO.
   - overrun=1 and stays 1.
   - alu_a is unchanged and the frame completes normally.
5. Async reset in EXEC: assert rst for half a cycle.
   - All outputs read 0 before the next clk edge.
   - tx_send never pulses.
6. SEND_HI_EN: stub alu_lo=0x1234, alu_hi=0xABCD.
   - Two tx_send pulses, carrying 0x1234 then 0xABCD.
   - The second pulse comes one cycle after the first tx_done.
   - busy drops after the second tx_done.
